// File: rtl/router_out_arb_if.sv
// Handshake bundle between the input ports and one router output arbiter.
// The bench drives the master side; the arbiter sits on the slave side.
interface router_out_arb_if #(
    parameter int NUM_IN = 16,
    parameter int IDX_W  = 4
);
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] din;
    logic [NUM_IN-1:0] frame_n;
    logic [NUM_IN-1:0] valid_n;
    logic [NUM_IN-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [NUM_IN-1:0] busy_n;
    logic              dout;
    logic              frameo_n;
    logic              valido_n;
    logic              timeout;

    modport master (
        output req, din, frame_n, valid_n,
        input  grant, grant_idx, busy_n, dout, frameo_n, valido_n, timeout
    );

    modport slave (
        input  req, din, frame_n, valid_n,
        output grant, grant_idx, busy_n, dout, frameo_n, valido_n, timeout
    );
endinterface

// File: rtl/router_out_arb.sv
// Round-robin owner arbitration for one router output port, forwarding the
// winning input's serial stream with one registered cycle of latency.
module router_out_arb #(
    parameter int NUM_IN  = 16,
    parameter int IDX_W   = 4,
    parameter int MAX_CYC = 4096
) (
    input  logic             clock,
    input  logic             reset_n,
    router_out_arb_if.slave  bus
);
    localparam int               CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [NUM_IN-1:0] grant_q, grant_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [IDX_W-1:0]  ptr_q, ptr_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              dout_q, dout_nxt;
    logic              frameo_q, frameo_nxt;
    logic              valido_q, valido_nxt;
    logic              timeout_q, timeout_nxt;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic              eop;
    logic              wd_hit;

    // Scan downwards so the candidate closest to ptr is the last one written.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_IN);
            if (bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_q;
        idx_nxt     = idx_q;
        ptr_nxt     = ptr_q;
        cnt_nxt     = cnt_q;
        dout_nxt    = 1'b0;
        frameo_nxt  = 1'b1;
        valido_nxt  = 1'b1;
        timeout_nxt = 1'b0;
        eop         = bus.frame_n[idx_q] & ~bus.valid_n[idx_q];
        wd_hit      = (cnt_q == CNT_LAST);

        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt           = ACTIVE;
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    idx_nxt             = pick_idx;
                    ptr_nxt             = IDX_W'((int'(pick_idx) + 1) % NUM_IN);
                    cnt_nxt             = '0;
                end
            end
            ACTIVE: begin
                // End of packet wins over a watchdog expiry on the same edge.
                if (eop || !wd_hit) begin
                    dout_nxt   = bus.din[idx_q];
                    frameo_nxt = bus.frame_n[idx_q];
                    valido_nxt = bus.valid_n[idx_q];
                end
                if (eop || wd_hit) begin
                    state_nxt   = GAP;
                    grant_nxt   = '0;
                    idx_nxt     = '0;
                    timeout_nxt = ~eop;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= 1'b0;
            frameo_q  <= 1'b1;
            valido_q  <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            idx_q     <= idx_nxt;
            ptr_q     <= ptr_nxt;
            cnt_q     <= cnt_nxt;
            dout_q    <= dout_nxt;
            frameo_q  <= frameo_nxt;
            valido_q  <= valido_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy_n    = ~(bus.req & ~grant_q);
    assign bus.dout      = dout_q;
    assign bus.frameo_n  = frameo_q;
    assign bus.valido_n  = valido_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_router_out_arb.sv
// Randomized and directed bench for router_out_arb against a cycle-stepped
// ownership model; MAX_CYC is shortened so the watchdog is reachable.
module tb_router_out_arb;
    localparam int N    = 16;
    localparam int IW   = 4;
    localparam int MAXC = 16;

    logic clock = 1'b0;
    logic reset_n;

    router_out_arb_if #(.NUM_IN(N), .IDX_W(IW)) bus ();

    router_out_arb #(.NUM_IN(N), .IDX_W(IW), .MAX_CYC(MAXC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Source-side stimulus state
    logic [N-1:0] req_v, din_v, frame_v, valid_v;
    int plen [N];
    int sent [N];
    bit rearm, rand_mode;

    assign bus.req     = req_v;
    assign bus.din     = din_v;
    assign bus.frame_n = frame_v;
    assign bus.valid_n = valid_v;

    // Reference model state: who owns the port, for how long, and what shows on the output
    int m_owner, m_ptr, m_held;
    bit m_gap, m_dout, m_frameo_n, m_valido_n, m_timeout;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_held = 0; m_gap = 0;
        m_dout = 0; m_frameo_n = 1; m_valido_n = 1; m_timeout = 0;
    endtask

    task automatic model_step();
        bit last;
        int j;
        m_timeout = 0; m_dout = 0; m_frameo_n = 1; m_valido_n = 1;
        if (m_owner >= 0) begin
            last = frame_v[m_owner] && !valid_v[m_owner];
            if (last || m_held < MAXC - 1) begin
                m_dout     = din_v[m_owner];
                m_frameo_n = frame_v[m_owner];
                m_valido_n = valid_v[m_owner];
            end
            if (last) begin
                m_owner = -1; m_gap = 1;
            end else if (m_held == MAXC - 1) begin
                m_owner = -1; m_gap = 1; m_timeout = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (req_v != 0) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (req_v[j]) begin
                    m_owner = j; m_ptr = (j + 1) % N; m_held = 0;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg, eb;
        int ei;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        eb = ~(req_v & ~eg);
        ei = (m_owner >= 0) ? m_owner : 0;
        check_eq("grant", bus.grant, eg);
        check_eq("grant_idx", bus.grant_idx, ei);
        check_eq("busy_n", bus.busy_n, eb);
        check_eq("dout", bus.dout, m_dout);
        check_eq("frameo_n", bus.frameo_n, m_frameo_n);
        check_eq("valido_n", bus.valido_n, m_valido_n);
        check_eq("timeout", bus.timeout, m_timeout);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (m_owner == i) begin
                din_v[i] = 1'($urandom % 2);
                if (sent[i] < plen[i]) begin
                    if (sent[i] == plen[i] - 1) begin
                        frame_v[i] = 1'b1; valid_v[i] = 1'b0;
                    end else begin
                        frame_v[i] = 1'b0; valid_v[i] = ($urandom % 4 == 0);
                    end
                    sent[i]++;
                end else begin
                    frame_v[i] = 1'b0; valid_v[i] = 1'b1;
                end
                if (rand_mode) req_v[i] = 1'($urandom % 2);
            end else begin
                frame_v[i] = 1'b1; valid_v[i] = 1'b1; din_v[i] = 1'($urandom % 2);
                if (sent[i] > 0) begin
                    sent[i] = 0;
                    if (!rearm) req_v[i] = 1'b0;
                end
                if (rand_mode && !req_v[i] && ($urandom % 8 == 0)) begin
                    req_v[i] = 1'b1; plen[i] = $urandom_range(1, 20);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
        drive_inputs();
    endtask

    task automatic arm(input int i, input int len);
        req_v[i] = 1'b1; plen[i] = len; sent[i] = 0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < bound) begin
            cycle();
            n++;
            done = (m_owner < 0) && !m_gap && (req_v == 0);
        end
        check_eq(tag, done, 1);
    endtask

    task automatic clear_sources();
        req_v = '0; din_v = '0; frame_v = '1; valid_v = '1;
        for (int i = 0; i < N; i++) begin
            plen[i] = 0; sent[i] = 0;
        end
    endtask

    // Asserts reset between edges and checks the outputs drop without a clock.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check_eq({tag, "_grant"}, bus.grant, 0);
        check_eq({tag, "_idx"}, bus.grant_idx, 0);
        check_eq({tag, "_dout"}, bus.dout, 0);
        check_eq({tag, "_frameo_n"}, bus.frameo_n, 1);
        check_eq({tag, "_valido_n"}, bus.valido_n, 1);
        check_eq({tag, "_timeout"}, bus.timeout, 0);
        model_reset();
        clear_sources();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int k, to_at, to_cnt;
        bit prev, seen;

        reset_n = 1'b0;
        rearm = 0; rand_mode = 0;
        clear_sources();
        model_reset();
        repeat (2) @(negedge clock);
        check_eq("rst_grant", bus.grant, 0);
        check_eq("rst_idx", bus.grant_idx, 0);
        check_eq("rst_busy_n", bus.busy_n, 16'hFFFF);
        check_eq("rst_frameo_n", bus.frameo_n, 1);
        check_eq("rst_valido_n", bus.valido_n, 1);
        check_eq("rst_dout", bus.dout, 0);
        check_eq("rst_timeout", bus.timeout, 0);
        reset_n = 1'b1;

        // Single packet on input 0
        arm(0, 10);
        cycle();
        check_eq("t1_grant", bus.grant, 16'h0001);
        wait_idle("t1_done", 40);

        // Grant input 4 so ptr=5, then scan wraps to input 3
        arm(4, 3);
        wait_idle("ptr_setup_done", 40);
        arm(3, 3);
        arm(4, 3);
        cycle();
        check_eq("ptr_wrap", bus.grant_idx, 3);
        wait_idle("ptr_done", 60);

        // Input 2 never ends its frame; watchdog must release it
        arm(2, 100);
        cycle();
        check_eq("to_grant", bus.grant_idx, 2);
        arm(7, 2);
        seen = 0; to_at = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            cycle();
            if (bus.timeout) begin
                seen = 1; to_at = c;
            end
        end
        check_eq("to_seen", seen, 1);
        check_eq("to_cycle", to_at, 16);
        cycle();
        cycle();
        check_eq("to_next", bus.grant_idx, 7);
        wait_idle("to_done", 40);

        // Last bit lands on the watchdog edge: treated as a normal end
        arm(8, 16);
        to_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (bus.timeout) to_cnt++;
        end
        check_eq("sim_timeout", to_cnt, 0);
        check_eq("sim_idle", (m_owner < 0) && (req_v == 0), 1);
        arm(9, 4);
        wait_idle("sim_next_done", 40);

        // Reset in the middle of a payload
        arm(0, 12);
        repeat (6) cycle();
        async_reset("mid_rst");
        arm(0, 2);
        arm(4, 2);
        cycle();
        check_eq("rst_first", bus.grant_idx, 0);
        wait_idle("rst_done", 40);

        // All inputs requesting continuously: strict rotation
        async_reset("fair_rst");
        rearm = 1;
        for (int i = 0; i < N; i++) arm(i, 1);
        k = 0; prev = 0;
        for (int c = 0; c < 200 && k < 17; c++) begin
            cycle();
            if (bus.grant != 0 && !prev) begin
                check_eq("fair_seq", bus.grant_idx, k % 16);
                k++;
            end
            prev = (bus.grant != 0);
        end
        check_eq("fair_count", k, 17);
        rearm = 0;
        req_v = '0;
        wait_idle("fair_done", 40);

        // Random traffic including over-long packets
        rand_mode = 1;
        repeat (1500) cycle();
        rand_mode = 0;
        req_v = '0;
        wait_idle("rand_done", 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/router_out_arb.md
Name: router_out_arb

Overview:
- Per-output-port arbiter and sequencer for the 16-port serial router.
- Grants one of NUM_IN input ports ownership of a single output port, round-robin.
- Forwards the winner's serial din/valid_n/frame_n stream to the output with one-cycle registered latency.
- Releases the port at end of packet or on a watchdog timeout; 16 instances form the router switch fabric.

Parameters:
- NUM_IN, 16, number of requesting input ports.
- IDX_W, 4, width of grant index (clog2(NUM_IN)).
- MAX_CYC, 4096, maximum cycles a grant may be held before forced release.

Ports:
- clock  input  1  single clock, all state on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_IN  req[i]=1: input i holds a decoded packet targeting this output.
- din  input  NUM_IN  serial data per input.
- frame_n  input  NUM_IN  active-low frame per input.
- valid_n  input  NUM_IN  active-low valid per input.
- grant  output  NUM_IN  one-hot registered grant, all-zero when idle.
- grant_idx  output  IDX_W  index of granted input, 0 when idle.
- busy_n  output  NUM_IN  busy_n[i]=0 when req[i]=1 and grant[i]=0 (combinational).
- dout  output  1  forwarded serial data.
- frameo_n  output  1  forwarded frame, active-low.
- valido_n  output  1  forwarded valid, active-low.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, grant=0, grant_idx=0, dout=0, frameo_n=1, valido_n=1, timeout=0, priority pointer ptr=0, watchdog cnt=0.
- States: IDLE, ACTIVE, GAP.
- IDLE:
  - If req!=0 at an edge, pick the first set req[j] scanning j=ptr, ptr+1, … mod NUM_IN.
  - At that same edge: grant[j]=1, grant_idx=j, ptr=(j+1) mod NUM_IN, cnt=0, state→ACTIVE.
  - If req==0, stay in IDLE with outputs idle.
- ACTIVE:
  - Each edge: dout<=din[g], frameo_n<=frame_n[g], valido_n<=valid_n[g], where g=grant_idx.
  - Latency: exactly 1 cycle from input sample to output.
  - End of packet: frame_n[g]=1 and valid_n[g]=0 sampled at an edge (last bit). That bit is forwarded at this edge, then state→GAP and grant cleared at the same edge.
  - Watchdog: cnt increments each ACTIVE cycle. When cnt reaches MAX_CYC-1 without end of packet:
    - state→GAP, grant cleared, frameo_n=1, valido_n=1.
    - timeout=1 for one cycle.
  - req[g] dropping in ACTIVE is ignored; only end of packet or timeout releases the port.
  - Other req changes do not affect the current grant.
- GAP (one cycle):
  - Outputs idle (frameo_n=1, valido_n=1, dout=0); no arbitration.
  - state→IDLE.
  - Guarantees at least one idle output cycle between packets.
- Fairness:
  - The last winner has lowest priority next round.
  - With all 16 requesting continuously, grants go 0,1,2,…,15,0.
- ptr wraps from NUM_IN-1 to 0.
- Simultaneous end of packet and timeout on the same edge: treated as normal end; timeout stays 0.
- Reset mid-packet: outputs return to idle immediately (async); no partial frame completion.
- grant is never multi-hot; grant!=0 only in ACTIVE.

Test Plan:
- Reset, then req=0x0001; input 0 sends addr+pad+1 byte → grant=0x0001 one cycle after req; dout mirrors din[0] delayed by 1 cycle; frameo_n rises 1 cycle after frame_n[0]; grant clears; 1 GAP cycle follows.
- req=0xFFFF held, each input sends a 1-byte packet → grant_idx sequence 0,1,…,15,0; busy_n=0 for every non-granted requester.
- ptr=5 after granting input 4; req=0x0018 (inputs 3,4) → input 4? No: scan starts at 5, wraps, first hit is 3 → grant_idx=3, ptr=4.
- Input 2 granted, holds frame_n[2]=0 indefinitely, with MAX_CYC=16 → after 16 ACTIVE cycles timeout pulses 1 cycle, frameo_n=1, next grant goes to another requester.
- reset_n low mid-payload → grant=0, frameo_n=1, valido_n=1, dout=0 asynchronously; after release, ptr=0 and input 0 wins first.
- Last bit and timeout on the same edge (MAX_CYC tuned) → timeout=0, normal GAP, next packet forwarded correctly.
